// File: rtl/muldiv_sched.sv
// Multiply/divide sequencer and HI/LO owner beside EX: iterative shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: mult/multu complete in the accept cycle via a single-cycle multiplier.
module muldiv_sched #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_mult,
  input  logic              op_multu,
  input  logic              op_div,
  input  logic              op_divu,
  input  logic              op_mthi,
  input  logic              op_mtlo,
  input  logic              annul,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              stallreq,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_next;

  logic              is_mul_op, is_div_op, is_signed_op;
  logic              start, div_zero, fast_mul, s1, s2;
  logic [DATA_W-1:0] abs1, abs2;

  logic [CNT_W-1:0]  cnt;
  logic              is_div, sign_q, sign_r;
  logic [DATA_W-1:0] acc_p, acc_a, opnd_b;

  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic                div_ge, last;
  logic [DATA_W-1:0]   step_p, step_a, res_hi, res_lo;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    is_mul_op    = op_mult | op_multu;
    is_div_op    = op_div | op_divu;
    is_signed_op = op_mult | op_div;
    start        = (is_mul_op | is_div_op) & ~annul;
    div_zero     = is_div_op & (src2 == '0);
    s1           = is_signed_op & src1[DATA_W-1];
    s2           = is_signed_op & src2[DATA_W-1];
    abs1         = s1 ? -src1 : src1;
    abs2         = s2 ? -src2 : src2;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_mag, fast_prod;
  always_comb begin
    fast_mag  = {{DATA_W{1'b0}}, abs1} * {{DATA_W{1'b0}}, abs2};
    fast_prod = (s1 ^ s2) ? -fast_mag : fast_mag;
    fast_mul  = is_mul_op;
  end
`else
  always_comb fast_mul = 1'b0;
`endif

  // {acc_p, acc_a} is the product register (multiply) or remainder:dividend pair (divide).
  always_comb begin
    mul_sum   = {1'b0, acc_p} + (acc_a[0] ? {1'b0, opnd_b} : '0);
    div_shift = {acc_p, acc_a[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    div_ge    = ~div_diff[DATA_W];
    if (is_div) begin
      step_p = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
      step_a = {acc_a[DATA_W-2:0], div_ge};
    end else begin
      step_p = mul_sum[DATA_W:1];
      step_a = {mul_sum[0], acc_a[DATA_W-1:1]};
    end
    prod = sign_q ? -{step_p, step_a} : {step_p, step_a};
    if (is_div) begin
      res_hi = sign_r ? -step_p : step_p;
      res_lo = sign_q ? -step_a : step_a;
    end else begin
      res_hi = prod[2*DATA_W-1:DATA_W];
      res_lo = prod[DATA_W-1:0];
    end
    last = (cnt == CNT_W'(DATA_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stallreq   = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        stallreq = start;
        if (start) state_next = (div_zero || fast_mul) ? FINISH : RUN;
      end
      RUN: begin
        stallreq = ~annul;
        if (annul)     state_next = IDLE;
        else if (last) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc_p  <= '0;
      acc_a  <= '0;
      opnd_b <= '0;
      is_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_p  <= '0;
            acc_a  <= abs1;
            opnd_b <= abs2;
            cnt    <= '0;
            is_div <= is_div_op;
            sign_q <= s1 ^ s2;
            sign_r <= s1;
            if (div_zero) begin
              hi <= src1;
              lo <= '1;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (is_mul_op) begin
              hi <= fast_prod[2*DATA_W-1:DATA_W];
              lo <= fast_prod[DATA_W-1:0];
            end
`endif
          end else if (!annul) begin
            if (op_mthi) hi <= src1;
            if (op_mtlo) lo <= src1;
          end
        end
        RUN: begin
          if (!annul) begin
            acc_p <= step_p;
            acc_a <= step_a;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO register owner, sitting beside the EX stage of the 5-stage MIPS pipeline.
- Accepts one mult/multu/div/divu at a time from EX and runs an iterative shift-add multiplier or a restoring divider.
- Raises stallreq to the pipeline stall controller while busy, then commits the 64-bit result to HI/LO.
- Also services mthi/mtlo writes. HI/LO outputs feed mfhi/mflo in EX.

Parameters:
DATA_W, 32, operand and HI/LO width; the iteration counter is clog2(DATA_W) bits.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
op_mult  in  1  EX holds signed multiply
op_multu  in  1  EX holds unsigned multiply
op_div  in  1  EX holds signed divide
op_divu  in  1  EX holds unsigned divide
op_mthi  in  1  write src1 to HI
op_mtlo  in  1  write src1 to LO
annul  in  1  flush; kills the pending or running operation
src1  in  DATA_W  rs value (dividend / multiplicand / mthi-mtlo data)
src2  in  DATA_W  rt value (divisor / multiplier)
stallreq  out  1  hold the pipeline
done  out  1  one-cycle pulse when HI/LO commit from an operation
busy  out  1  FSM not IDLE
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register

Behaviour:
Reset:
- State IDLE; hi = lo = 0; done = busy = 0; stallreq = 0.
- Reset mid-operation aborts immediately; hi/lo return to 0.

States: IDLE, RUN, FINISH.

start = (op_mult | op_multu | op_div | op_divu) & ~annul, sampled only in IDLE.

IDLE:
- On start, on the same cycle:
  - latch |src1| and |src2| (absolute value only for signed ops);
  - latch sign_q = s1 ^ s2 and sign_r = s1;
  - clear the counter; go to RUN.
- stallreq = start, combinational, so EX holds on the accept cycle.
- If divide and src2 == 0:
  - skip RUN; go directly to FINISH;
  - commit LO = all-ones, HI = src1.
  - Total stall is 1 cycle.
- mthi/mtlo, only when start = 0 and annul = 0: hi or lo <= src1 at the next edge. No stall.
- start has priority over mthi/mtlo.

RUN:
- One iteration per cycle, counter 0..DATA_W-1.
- stallreq = 1, busy = 1.
- Multiply: 64-bit shift-add on the magnitudes.
- Divide: restoring, one quotient bit per cycle.
- On the edge ending counter = DATA_W-1:
  - apply signs (negate quotient if sign_q, negate remainder if sign_r; multiply negates the product if sign_q);
  - write hi/lo; go to FINISH.
- Arithmetic is modulo 2^DATA_W. Therefore 0x80000000 / -1 gives LO = 0x80000000, HI = 0.

FINISH:
- Exactly 1 cycle. stallreq = 0, done = 1, busy = 1.
- Op inputs are ignored, because the same EX instruction is still presenting its op.
- Next state is IDLE.

Latency:
- Accept cycle plus DATA_W RUN cycles, so stallreq is high for DATA_W+1 consecutive cycles.
- done is asserted on the following cycle.

Annul:
- annul in RUN returns to IDLE at the next edge; hi/lo are unchanged; done never fires.
- stallreq drops in the cycle annul is asserted.
- annul in FINISH is a no-op: the result is already committed.

Other rules:
- Ops asserted simultaneously: illegal; the decode guarantees they are one-hot.
- hi/lo change only at a commit edge or an mthi/mtlo edge.

Optional Feature:
Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - mult/multu bypass RUN; the product is computed by a single-cycle DATA_W x DATA_W multiplier;
  - the accept cycle goes to FINISH with HI/LO written at that edge;
  - stallreq is high for exactly 1 cycle.
- Undefined: multiply is iterative, as described under Behaviour.
- Divide behaviour is identical either way.

Test Plan:
1. divu src1=100, src2=7 -> stallreq high 33 cycles; done next cycle; LO=14, HI=2.
2. div src1=-7 (0xFFFFFFF9), src2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. div src1=0x80000000, src2=0xFFFFFFFF -> LO=0x80000000, HI=0; divu src1=5, src2=0 -> 1 stall cycle, LO=0xFFFFFFFF, HI=5.
4. mult 0xFFFFFFFF x 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=1, LO=0xFFFFFFFE. Stall is 33 cycles, or 1 with MULDIV_FAST_MUL_EN.
5. mthi src1=0x1234, then mtlo src1=0x5678 -> no stall; hi=0x1234, lo=0x5678. Then divu 9/3 with annul pulsed at counter=10 -> IDLE next cycle; hi/lo still 0x1234/0x5678; no done.
6. rst asserted at counter=5 of a multu -> next cycle IDLE, hi=lo=0, stallreq=0. A new divu 8/2 issued after reset completes with LO=4, HI=0.
